// File: rtl/zx81_tape_encoder_if.sv
// rtl/zx81_tape_encoder_if.sv - byte stream handshake into the ZX81 tape encoder
interface zx81_tape_encoder_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/zx81_tape_encoder.sv
// rtl/zx81_tape_encoder.sv - .P byte stream to ZX80/ZX81 cassette pulse waveform
// Each bit is a burst of 4 ('0') or 9 ('1') square pulses plus silence, MSB first.
module zx81_tape_encoder #(
   parameter int PULSE_HI = 975,
   parameter int PULSE_LO = 975,
   parameter int BIT_GAP  = 8450,
   parameter int PRE_GAP  = 3250000,
   parameter int POST_GAP = 3250000,
   parameter int CNT_W    = 23
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   enable,
   zx81_tape_encoder_if.slave     s,
   output logic                   tape_out,
   output logic                   busy,
   output logic                   done
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LEAD  = 3'd1;
   localparam logic [2:0] FETCH = 3'd2;
   localparam logic [2:0] HI    = 3'd3;
   localparam logic [2:0] LO    = 3'd4;
   localparam logic [2:0] GAP   = 3'd5;
   localparam logic [2:0] TAIL  = 3'd6;

   logic [2:0]       state, state_nx;
   logic [CNT_W-1:0] timer, timer_ld;
   logic [7:0]       shift;
   logic [2:0]       bit_cnt;
   logic [3:0]       pulses;
   logic             last_r;
   logic             timer_z;

   assign timer_z = (timer == '0);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (s.s_valid) state_nx = LEAD;
         LEAD:    if (timer_z) state_nx = FETCH;
         FETCH:   if (s.s_valid) state_nx = HI;
         HI:      if (timer_z) state_nx = LO;
         LO:      if (timer_z) state_nx = (pulses > 4'd1) ? HI : GAP;
         GAP:     if (timer_z) state_nx = (bit_cnt != 3'd0) ? HI : (last_r ? TAIL : FETCH);
         TAIL:    if (timer_z) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // Abort wins over everything, including a pending FETCH handshake.
      if (!enable) state_nx = IDLE;
   end

   always_comb begin
      timer_ld = '0;
      case (state_nx)
         LEAD:    timer_ld = CNT_W'(PRE_GAP - 1);
         HI:      timer_ld = CNT_W'(PULSE_HI - 1);
         LO:      timer_ld = CNT_W'(PULSE_LO - 1);
         GAP:     timer_ld = CNT_W'(BIT_GAP - 1);
         TAIL:    timer_ld = CNT_W'(POST_GAP - 1);
         default: timer_ld = '0;
      endcase
   end

   // Outputs are registered from the next state so they line up with state.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= IDLE;
         timer     <= '0;
         shift     <= '0;
         bit_cnt   <= '0;
         pulses    <= '0;
         last_r    <= 1'b0;
         tape_out  <= 1'b0;
         s.s_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         tape_out  <= (state_nx == HI);
         s.s_ready <= (state_nx == FETCH);
         busy      <= (state_nx != IDLE);
         done      <= enable && (state == TAIL) && timer_z;

         // Every phase change is a state change, so entry reloads the timer.
         if (state_nx != state)
            timer <= timer_ld;
         else if (!timer_z)
            timer <= timer - CNT_W'(1);

         if (state == FETCH && state_nx == HI) begin
            shift   <= s.s_data;
            last_r  <= s.s_last;
            bit_cnt <= 3'd7;
            pulses  <= s.s_data[7] ? 4'd9 : 4'd4;
         end else if (state == GAP && state_nx == HI) begin
            shift   <= shift << 1;
            bit_cnt <= bit_cnt - 3'd1;
            pulses  <= shift[6] ? 4'd9 : 4'd4;
         end else if (state == LO && timer_z) begin
            pulses  <= pulses - 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_zx81_tape_encoder.sv
// tb/tb_zx81_tape_encoder.sv - randomized scoreboard bench for zx81_tape_encoder
module tb_zx81_tape_encoder;

   localparam int PH   = 4;
   localparam int PL   = 4;
   localparam int GAPC = 20;
   localparam int PRE  = 50;
   localparam int POST = 30;

   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   logic n_reset;
   logic enable;
   logic tape_out, busy, done;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] exp_q[$];

   zx81_tape_encoder_if sif();

   zx81_tape_encoder #(
      .PULSE_HI(PH), .PULSE_LO(PL), .BIT_GAP(GAPC),
      .PRE_GAP(PRE), .POST_GAP(POST), .CNT_W(23)
   ) dut (
      .clk(clk), .n_reset(n_reset), .enable(enable), .s(sif),
      .tape_out(tape_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int byte_cycles(input logic [7:0] b);
      int ones = $countones(b);
      return ones * (9 * (PH + PL) + GAPC) + (8 - ones) * (4 * (PH + PL) + GAPC);
   endfunction

   // Monitor: decode bursts by counting rising edges, pop expected bytes.
   int         m_pulses, m_low, m_high, m_nbits;
   logic       m_prev;
   logic [7:0] m_bits;
   initial begin
      m_pulses = 0; m_low = 0; m_high = 0; m_nbits = 0; m_prev = 0; m_bits = 0;
      forever begin
         @(negedge clk);
         if (n_reset !== 1'b1 || busy !== 1'b1) begin
            m_pulses = 0; m_low = 0; m_high = 0; m_nbits = 0; m_prev = 0; m_bits = 0;
         end else if (tape_out === 1'b1) begin
            if (!m_prev) m_pulses++;
            m_high++; m_low = 0; m_prev = 1;
         end else begin
            if (m_prev) check("pulse_high_width", m_high, PH);
            m_high = 0; m_prev = 0; m_low++;
            if (m_low == PL + 1 && m_pulses != 0) begin
               vectors++;
               if (m_pulses != 4 && m_pulses != 9) begin
                  miscompares++;
                  $display("FAIL burst_pulse_count: got %0d, expected 4 or 9", m_pulses);
               end
               m_bits = {m_bits[6:0], (m_pulses == 9)};
               m_nbits++; m_pulses = 0;
               if (m_nbits == 8) begin
                  if (exp_q.size() == 0) begin
                     vectors++; miscompares++;
                     $display("FAIL unexpected_byte: got %0h, expected none", m_bits);
                  end else begin
                     check("decoded_byte", m_bits, exp_q.pop_front());
                  end
                  m_nbits = 0;
               end
            end
         end
      end
   end

   // Play a whole file with s_valid held; check total duration and handshakes.
   task automatic run_file(input byte_q_t bytes);
      int n = bytes.size();
      int expect_len = PRE + POST;
      int c0 = 0, c1 = 0, sr_cnt = 0, i = 0, limit;
      bit done_seen = 0;
      foreach (bytes[k]) expect_len += 1 + byte_cycles(bytes[k]);
      limit = expect_len + 200;
      @(negedge clk);
      sif.s_data = bytes[0]; sif.s_last = (n == 1); sif.s_valid = 1'b1;
      @(negedge clk);
      c0 = cyc;
      for (int t = 0; t < limit && !done_seen; t++) begin
         @(negedge clk);
         if (done === 1'b1) begin c1 = cyc; done_seen = 1; end
         if (sif.s_ready === 1'b1) begin
            sr_cnt++;
            if (i < n) begin
               exp_q.push_back(bytes[i]);
               i++;
               @(posedge clk); #1;
               if (i < n) begin sif.s_data = bytes[i]; sif.s_last = (i == n - 1); end
               else sif.s_valid = 1'b0;
            end
         end
      end
      sif.s_valid = 1'b0;
      check("done_seen", done_seen, 1);
      check("file_duration", c1 - c0, expect_len);
      check("s_ready_cycles", sr_cnt, n);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 0;
      for (int t = 0; t < PRE + 20 && !ok; t++) begin
         @(negedge clk);
         if (sif.s_ready === 1'b1) ok = 1;
      end
      if (!ok) check("s_ready_timeout", 0, 1);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      byte_q_t q;
      bit ok;
      int bad;
      n_reset = 1'b0; enable = 1'b0;
      sif.s_data = 8'h00; sif.s_valid = 1'b0; sif.s_last = 1'b0;
      #12;
      check("reset_tape_out", tape_out, 0);
      check("reset_busy", busy, 0);
      check("reset_s_ready", sif.s_ready, 0);
      check("reset_done", done, 0);
      @(negedge clk); n_reset = 1'b1; enable = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);

      // 1: single byte 0x80
      q = {8'h80};
      run_file(q);

      // 2: 0x00 then 0xFF back-to-back
      q = {8'h00, 8'hFF};
      run_file(q);

      // 3: underrun between two bytes
      @(negedge clk);
      sif.s_data = 8'h5A; sif.s_last = 1'b0; sif.s_valid = 1'b1;
      wait_ready(ok);
      exp_q.push_back(8'h5A);
      @(posedge clk); #1; sif.s_valid = 1'b0;
      repeat (byte_cycles(8'h5A) + 1) @(negedge clk);
      bad = 0;
      for (int t = 0; t < 100; t++) begin
         if (tape_out !== 1'b0 || busy !== 1'b1 || sif.s_ready !== 1'b1) bad++;
         @(negedge clk);
      end
      check("underrun_line_state", bad, 0);
      sif.s_data = 8'hC3; sif.s_last = 1'b1; sif.s_valid = 1'b1;
      exp_q.push_back(8'hC3);
      @(posedge clk); #1; sif.s_valid = 1'b0;
      @(negedge clk);
      check("underrun_resume_hi", tape_out, 1);
      ok = 0;
      for (int t = 0; t < byte_cycles(8'hC3) + POST + 50 && !ok; t++) begin
         @(negedge clk);
         if (done === 1'b1) ok = 1;
      end
      check("underrun_done", ok, 1);

      // 4: enable low mid-burst of 0xA5, then replay with a fresh leader
      @(negedge clk);
      sif.s_data = 8'hA5; sif.s_last = 1'b1; sif.s_valid = 1'b1;
      wait_ready(ok);
      @(posedge clk); #1; sif.s_valid = 1'b0;
      repeat (30) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("abort_tape_out", tape_out, 0);
      check("abort_busy", busy, 0);
      check("abort_s_ready", sif.s_ready, 0);
      bad = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (done !== 1'b0 || tape_out !== 1'b0) bad++;
      end
      check("abort_quiet", bad, 0);
      enable = 1'b1;
      q = {8'h3C};
      run_file(q);

      // 5: async reset mid-HI
      @(negedge clk);
      sif.s_data = 8'h81; sif.s_last = 1'b1; sif.s_valid = 1'b1;
      wait_ready(ok);
      @(posedge clk); #1; sif.s_valid = 1'b0;
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (tape_out === 1'b1) ok = 1;
      end
      check("reach_hi", ok, 1);
      #2 n_reset = 1'b0;
      #1;
      check("async_rst_tape_out", tape_out, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_s_ready", sif.s_ready, 0);
      @(negedge clk); n_reset = 1'b1;
      @(negedge clk);

      // 6: 100 random bytes
      q = {};
      for (int k = 0; k < 100; k++) q.push_back(8'($urandom_range(0, 255)));
      run_file(q);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
